// File: rtl/parity_pkg.sv
// parity_pkg: shared lane math and parity-mode type for the parity lane checker
package parity_pkg;
  typedef enum logic {PAR_EVEN = 1'b0, PAR_ODD = 1'b1} par_mode_e;
  function automatic int lanes(input int width, input int lane);
    return width / lane;
  endfunction
  function automatic bit lanes_ok(input int width, input int lane);
    return lane > 0 && width % lane == 0;
  endfunction
endpackage

// File: rtl/lane_parity.sv
// lane_parity: XOR-reduce of one lane, inverted in odd-parity mode
module lane_parity
  import parity_pkg::*;
#(
  parameter int        LANE = 8,
  parameter par_mode_e MODE = PAR_EVEN
) (
  input  logic [LANE-1:0] i_data,
  output logic            o_par
);
  assign o_par = (^i_data) ^ (MODE == PAR_ODD);
endmodule

// File: rtl/parity_lane_checker.sv
// parity_lane_checker: per-lane parity generate/compare with registered errors and sticky/count status
module parity_lane_checker
  import parity_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANE  = 8,
  parameter int ODD   = 0,
  parameter int CNT_W = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [WIDTH-1:0]               in_data,
  input  logic [lanes(WIDTH, LANE)-1:0]  in_parity,
  input  logic                           clr_err,
  output logic                           out_valid,
  output logic [lanes(WIDTH, LANE)-1:0]  out_parity,
  output logic [lanes(WIDTH, LANE)-1:0]  out_err,
  output logic                           err_any,
  output logic                           err_sticky,
  output logic [CNT_W-1:0]               err_count
);
  localparam int        LANES = lanes(WIDTH, LANE);
  localparam par_mode_e MODE  = (ODD != 0) ? PAR_ODD : PAR_EVEN;
  if (!lanes_ok(WIDTH, LANE)) begin : g_bad_width
    $fatal(1, "parity_lane_checker: WIDTH must be a multiple of LANE");
  end
  logic [LANES-1:0] w_p, w_e, r_par, r_err;
  logic [CNT_W-1:0] w_cnt_base, r_cnt;
  logic             w_bad, w_stk_base, r_valid, r_stk;
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_parity #(.LANE(LANE), .MODE(MODE)) u_lane (
      .i_data(in_data[g*LANE +: LANE]),
      .o_par (w_p[g])
    );
  end
  assign w_e        = in_valid ? (w_p ^ in_parity) : '0;
  assign w_bad      = |w_e;
  // clear acts first so a coincident error lands on a zeroed status
  assign w_cnt_base = clr_err ? '0 : r_cnt;
  assign w_stk_base = clr_err ? 1'b0 : r_stk;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_par   <= '0;
      r_err   <= '0;
      r_stk   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_valid <= in_valid;
      r_err   <= w_e;
      if (in_valid) r_par <= w_p;
      r_stk   <= w_stk_base | w_bad;
      r_cnt   <= (w_bad && !(&w_cnt_base)) ? w_cnt_base + 1'b1 : w_cnt_base;
    end
  end
  assign out_valid  = r_valid;
  assign out_parity = r_par;
  assign out_err    = r_err;
  assign err_any    = |r_err;
  assign err_sticky = r_stk;
  assign err_count  = r_cnt;
endmodule
